// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the MIPS MEM stage: access-width encoding and alignment rule.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    WIDTH_BYTE    = 2'b00,
    WIDTH_HALF    = 2'b01,
    WIDTH_ILLEGAL = 2'b10,
    WIDTH_WORD    = 2'b11
  } width_e;

  // The unused 2'b10 encoding is reported as misaligned so it can never write memory.
  function automatic logic access_misaligned(input logic [1:0] width, input logic [1:0] lane);
    logic bad;
    case (width_e'(width))
      WIDTH_BYTE: bad = 1'b0;
      WIDTH_HALF: bad = lane[0];
      WIDTH_WORD: bad = |lane;
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_stage_data_memory.sv
// Byte-enable data RAM: one synchronous write port and two asynchronous read ports
// (pipeline access and debug dump). The synchronous reset clears every word.
module mem_stage_data_memory #(
  parameter int NB      = 32,
  parameter int NB_ADDR = 7
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_we,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB/8-1:0]    i_be,
  input  logic [NB-1:0]      i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB-1:0]      o_rd_data,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  output logic [NB-1:0]      o_dbg_data
);

  localparam int DEPTH = 2 ** NB_ADDR;

  logic [NB-1:0] mem_q [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int w = 0; w < DEPTH; w++) begin
        mem_q[w] <= '0;
      end
    end else if (i_we) begin
      for (int b = 0; b < NB / 8; b++) begin
        if (i_be[b]) begin
          mem_q[i_wr_addr][8*b +: 8] <= i_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Reads see the stored value, so a same-cycle write is not visible until after the edge.
  assign o_rd_data  = mem_q[i_rd_addr];
  assign o_dbg_data = mem_q[i_dbg_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: alignment check, store lane steering,
// load lane extract/extension and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int NB      = 32,
  parameter int NB_ADDR = 7,
  parameter int NB_REG  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_enable,
  input  logic [NB-1:0]      i_alu_result,
  input  logic [NB-1:0]      i_store_data,
  input  logic [NB_REG-1:0]  i_rd_addr,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_reg_write,
  input  logic               i_mem_to_reg,
  input  logic [1:0]         i_width,
  input  logic               i_unsigned,
  input  logic               i_halt,
  input  logic [NB_ADDR-1:0] i_debug_addr,
  output logic [NB-1:0]      o_alu_result,
  output logic [NB-1:0]      o_mem_data,
  output logic [NB_REG-1:0]  o_rd_addr,
  output logic               o_reg_write,
  output logic               o_mem_to_reg,
  output logic               o_halt,
  output logic               o_misaligned,
  output logic [NB-1:0]      o_debug_data
);

  localparam int NB_LANE = NB / 8;

  logic [NB_ADDR-1:0] word_idx;
  logic [1:0]         lane;
  logic               fault;
  logic               wr_en;
  logic [NB_LANE-1:0] wr_be;
  logic [NB-1:0]      wr_data;
  logic [NB-1:0]      rd_word;
  logic [NB-1:0]      rd_shift;
  logic [NB-1:0]      load_ext;

  // Upper address bits are ignored on purpose: the memory wraps around.
  logic unused_addr_bits;
  assign unused_addr_bits = ^i_alu_result[NB-1:NB_ADDR+2];

  assign word_idx = i_alu_result[NB_ADDR+1:2];
  assign lane     = i_alu_result[1:0];
  assign fault    = (i_mem_read | i_mem_write) & access_misaligned(i_width, lane);
  assign wr_en    = i_enable & i_mem_write & ~fault;

  always_comb begin
    wr_be   = '1;
    wr_data = i_store_data;
    case (width_e'(i_width))
      WIDTH_BYTE: begin
        wr_be   = NB_LANE'(1) << lane;
        wr_data = {NB_LANE{i_store_data[7:0]}};
      end
      WIDTH_HALF: begin
        wr_be   = NB_LANE'(3) << lane;
        wr_data = {(NB_LANE/2){i_store_data[15:0]}};
      end
      default: ;
    endcase
  end

  mem_stage_data_memory #(
    .NB      (NB),
    .NB_ADDR (NB_ADDR)
  ) u_data_memory (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_we       (wr_en),
    .i_wr_addr  (word_idx),
    .i_be       (wr_be),
    .i_wr_data  (wr_data),
    .i_rd_addr  (word_idx),
    .o_rd_data  (rd_word),
    .i_dbg_addr (i_debug_addr),
    .o_dbg_data (o_debug_data)
  );

  assign rd_shift = rd_word >> {lane, 3'b000};

  always_comb begin
    load_ext = rd_word;
    case (width_e'(i_width))
      WIDTH_BYTE: load_ext = i_unsigned ? {{(NB-8){1'b0}}, rd_shift[7:0]}
                                        : {{(NB-8){rd_shift[7]}}, rd_shift[7:0]};
      WIDTH_HALF: load_ext = i_unsigned ? {{(NB-16){1'b0}}, rd_shift[15:0]}
                                        : {{(NB-16){rd_shift[15]}}, rd_shift[15:0]};
      default: ;
    endcase
  end

  logic [NB-1:0]     alu_result_q, alu_result_d;
  logic [NB-1:0]     mem_data_q,   mem_data_d;
  logic [NB_REG-1:0] rd_addr_q;
  logic              reg_write_q,  reg_write_d;
  logic              mem_to_reg_q;
  logic              halt_q;
  logic              misaligned_q;

  assign alu_result_d = i_alu_result;
  assign mem_data_d   = (i_mem_read & ~fault) ? load_ext : '0;
  assign reg_write_d  = i_reg_write & ~(i_mem_read & fault);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      alu_result_q <= '0;
      mem_data_q   <= '0;
      rd_addr_q    <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      halt_q       <= 1'b0;
      misaligned_q <= 1'b0;
    end else if (i_enable) begin
      alu_result_q <= alu_result_d;
      mem_data_q   <= mem_data_d;
      rd_addr_q    <= i_rd_addr;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= i_mem_to_reg;
      halt_q       <= i_halt;
      misaligned_q <= fault;
    end
  end

  assign o_alu_result = alu_result_q;
  assign o_mem_data   = mem_data_q;
  assign o_rd_addr    = rd_addr_q;
  assign o_reg_write  = reg_write_q;
  assign o_mem_to_reg = mem_to_reg_q;
  assign o_halt       = halt_q;
  assign o_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: stores/loads of every width, alignment faults,
// enable hold, read-during-write, address wrap-around and reset clearing memory.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_enable = 1'b0;
  logic [31:0] i_alu_result = '0;
  logic [31:0] i_store_data = '0;
  logic [4:0]  i_rd_addr = '0;
  logic        i_mem_read = 1'b0;
  logic        i_mem_write = 1'b0;
  logic        i_reg_write = 1'b0;
  logic        i_mem_to_reg = 1'b0;
  logic [1:0]  i_width = 2'b00;
  logic        i_unsigned = 1'b0;
  logic        i_halt = 1'b0;
  logic [6:0]  i_debug_addr = '0;
  logic [31:0] o_alu_result;
  logic [31:0] o_mem_data;
  logic [4:0]  o_rd_addr;
  logic        o_reg_write;
  logic        o_mem_to_reg;
  logic        o_halt;
  logic        o_misaligned;
  logic [31:0] o_debug_data;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] WB = 2'b00, WH = 2'b01, WX = 2'b10, WW = 2'b11;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk        (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_alu_result (i_alu_result),
    .i_store_data (i_store_data),
    .i_rd_addr    (i_rd_addr),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_reg_write  (i_reg_write),
    .i_mem_to_reg (i_mem_to_reg),
    .i_width      (i_width),
    .i_unsigned   (i_unsigned),
    .i_halt       (i_halt),
    .i_debug_addr (i_debug_addr),
    .o_alu_result (o_alu_result),
    .o_mem_data   (o_mem_data),
    .o_rd_addr    (o_rd_addr),
    .o_reg_write  (o_reg_write),
    .o_mem_to_reg (o_mem_to_reg),
    .o_halt       (o_halt),
    .o_misaligned (o_misaligned),
    .o_debug_data (o_debug_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_dbg(input string tag, input logic [6:0] a, input logic [31:0] exp);
    i_debug_addr = a;
    #1;
    check(tag, o_debug_data, exp);
  endtask

  // One pipeline step: inputs applied at the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic op(input logic en, input logic rd, input logic wr, input logic [1:0] w,
                    input logic uns, input logic [31:0] addr, input logic [31:0] data,
                    input logic regw, input logic halt, input logic [4:0] rda);
    @(negedge clk);
    i_enable     = en;
    i_mem_read   = rd;
    i_mem_write  = wr;
    i_width      = w;
    i_unsigned   = uns;
    i_alu_result = addr;
    i_store_data = data;
    i_reg_write  = regw;
    i_mem_to_reg = rd;
    i_halt       = halt;
    i_rd_addr    = rda;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    i_reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_alu", o_alu_result, 32'h0);
    check("rst_mem_data", o_mem_data, 32'h0);
    check("rst_rd_addr", {27'h0, o_rd_addr}, 32'h0);
    check("rst_reg_write", {31'h0, o_reg_write}, 32'h0);
    check("rst_misaligned", {31'h0, o_misaligned}, 32'h0);
    check("rst_halt", {31'h0, o_halt}, 32'h0);
    check_dbg("rst_mem_w2", 7'd2, 32'h0);
    @(negedge clk);
    i_reset = 1'b0;

    // SW then LW
    op(1, 0, 1, WW, 0, 32'h08, 32'hDEADBEEF, 0, 0, 5'd0);
    check("sw_misaligned", {31'h0, o_misaligned}, 32'h0);
    check_dbg("sw_w2", 7'd2, 32'hDEADBEEF);
    op(1, 1, 0, WW, 0, 32'h08, 32'h0, 1, 0, 5'd3);
    check("lw_data", o_mem_data, 32'hDEADBEEF);
    check("lw_misaligned", {31'h0, o_misaligned}, 32'h0);
    check("lw_reg_write", {31'h0, o_reg_write}, 32'h1);
    check("lw_rd_addr", {27'h0, o_rd_addr}, 32'd3);
    check("lw_mem_to_reg", {31'h0, o_mem_to_reg}, 32'h1);

    // SB over a cleared word, then LB / LBU
    op(1, 0, 1, WW, 0, 32'h08, 32'h0, 0, 0, 5'd0);
    op(1, 0, 1, WB, 0, 32'h09, 32'h12345680, 0, 0, 5'd0);
    check_dbg("sb_w2", 7'd2, 32'h00008000);
    op(1, 1, 0, WB, 0, 32'h09, 32'h0, 1, 0, 5'd4);
    check("lb_data", o_mem_data, 32'hFFFFFF80);
    op(1, 1, 0, WB, 1, 32'h09, 32'h0, 1, 0, 5'd4);
    check("lbu_data", o_mem_data, 32'h00000080);

    // SH to the upper half, then LH / LHU
    op(1, 0, 1, WH, 0, 32'h06, 32'hFFFF8001, 0, 0, 5'd0);
    check_dbg("sh_w1", 7'd1, 32'h80010000);
    op(1, 1, 0, WH, 0, 32'h06, 32'h0, 1, 0, 5'd5);
    check("lh_data", o_mem_data, 32'hFFFF8001);
    op(1, 1, 0, WH, 1, 32'h06, 32'h0, 1, 0, 5'd5);
    check("lhu_data", o_mem_data, 32'h00008001);

    // Misaligned and illegal-width accesses
    op(1, 0, 1, WW, 0, 32'h0A, 32'h11111111, 0, 0, 5'd0);
    check("sw_mis_flag", {31'h0, o_misaligned}, 32'h1);
    check_dbg("sw_mis_w2", 7'd2, 32'h00008000);
    op(1, 1, 0, WH, 0, 32'h03, 32'h0, 1, 0, 5'd6);
    check("lh_mis_flag", {31'h0, o_misaligned}, 32'h1);
    check("lh_mis_reg_write", {31'h0, o_reg_write}, 32'h0);
    check("lh_mis_data", o_mem_data, 32'h0);
    op(1, 1, 1, WX, 0, 32'h08, 32'h22222222, 1, 0, 5'd6);
    check("illegal_flag", {31'h0, o_misaligned}, 32'h1);
    check("illegal_data", o_mem_data, 32'h0);
    check_dbg("illegal_w2", 7'd2, 32'h00008000);

    // Load and store together: store happens, load returns pre-write word
    op(1, 1, 1, WW, 0, 32'h08, 32'hCAFEF00D, 1, 1, 5'd7);
    check("rmw_data", o_mem_data, 32'h00008000);
    check("rmw_halt", {31'h0, o_halt}, 32'h1);
    check_dbg("rmw_w2", 7'd2, 32'hCAFEF00D);

    // Enable low: no write, outputs hold; then the write lands
    op(0, 0, 1, WW, 0, 32'h10, 32'hAAAA5555, 0, 0, 5'd9);
    check("hold_alu", o_alu_result, 32'h08);
    check("hold_data", o_mem_data, 32'h00008000);
    check("hold_halt", {31'h0, o_halt}, 32'h1);
    check_dbg("hold_w4", 7'd4, 32'h0);
    op(1, 0, 1, WW, 0, 32'h10, 32'hAAAA5555, 0, 0, 5'd9);
    check_dbg("en_w4", 7'd4, 32'hAAAA5555);
    check("en_alu", o_alu_result, 32'h10);
    check("en_halt", {31'h0, o_halt}, 32'h0);
    check("en_data", o_mem_data, 32'h0);

    // Address wrap-around
    op(1, 0, 1, WW, 0, 32'h200, 32'h12345678, 0, 0, 5'd0);
    check_dbg("wrap_w0", 7'd0, 32'h12345678);

    // Reset during a store: memory cleared, store suppressed
    @(negedge clk);
    i_reset      = 1'b1;
    i_enable     = 1'b1;
    i_mem_write  = 1'b1;
    i_mem_read   = 1'b0;
    i_width      = WW;
    i_alu_result = 32'h200;
    i_store_data = 32'h55555555;
    @(posedge clk);
    #1;
    check_dbg("rst_sw_w0", 7'd0, 32'h0);
    check_dbg("rst_sw_w2", 7'd2, 32'h0);
    check_dbg("rst_sw_w4", 7'd4, 32'h0);
    check("rst_sw_alu", o_alu_result, 32'h0);
    check("rst_sw_data", o_mem_data, 32'h0);
    @(negedge clk);
    i_reset     = 1'b0;
    i_mem_write = 1'b0;
    i_enable    = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
